// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset core:
// controller states, opcode/funct values and ALU operation select.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_ADDIEX,
    S_ALUWB,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_BRANCH,
    S_JUMP,
    S_JREG,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_ctrl_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  function automatic alu_ctrl_e funct_to_alu(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// NREG x XLEN register file: two asynchronous read ports, one synchronous
// write port, entry 0 reads as zero and ignores writes.
module mc_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [AW-1:0]   i_ra1,
  input  logic [AW-1:0]   i_ra2,
  input  logic            i_we,
  input  logic [AW-1:0]   i_wa,
  input  logic [XLEN-1:0] i_wd,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);

  logic [XLEN-1:0] r_mem [NREG];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == '0) ? '0 : r_mem[i_ra1];
  assign o_rd2 = (i_ra2 == '0) ? '0 : r_mem[i_ra2];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS-subset core: controller FSM, ALU and muxes sharing one
// ready-handshake memory port. jal/jr exist only with MC_DATAPATH_JAL_EN.
module mc_datapath
  import mc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc_q,
  output logic [XLEN-1:0] instr,
  output logic            reg_write_en,
  output logic            halted
);

  // state  | meaning
  // FETCH  | read IR at PC, PC <= PC+4 when ready
  // DECODE | latch A/B, dispatch on opcode
  // EXEC   | R-type ALU op into ALUOut
  // ADDIEX | A + imm into ALUOut
  // ALUWB  | write ALUOut to rd (R-type) or rt (addi)
  // MEMADR | A + imm into ALUOut and memory address
  // MEMRD  | load access, MDR <= rdata when ready
  // MEMWB  | write MDR to rt
  // MEMWR  | store access held until ready
  // BRANCH | beq resolve, redirect PC when A == B
  // JUMP   | j/jal target, jal links PC+4 into r[NREG-1]
  // JREG   | jr: PC <= A
  // HALT   | illegal instruction trap, terminal until reset

  localparam int AW = $clog2(NREG);

  state_e          r_state;
  logic [XLEN-1:0] r_pc, r_ir, r_a, r_b, r_aluout, r_mdr;
  logic [XLEN-1:0] r_mem_addr, r_mem_wdata;
  logic            r_mem_req, r_mem_we, r_reg_we, r_halted;

  logic [5:0]      w_op, w_funct;
  logic [AW-1:0]   w_rs, w_rt, w_rd, w_wa;
  logic [XLEN-1:0] w_imm, w_rd1, w_rd2, w_wd;
  logic [XLEN-1:0] w_alu_b, w_alu_y, w_pc_br, w_pc_jmp, w_pc_next;
  alu_ctrl_e       w_alu_ctrl;
  state_e          w_dec_state;

  assign w_op     = r_ir[31:26];
  assign w_funct  = r_ir[5:0];
  assign w_rs     = r_ir[21 +: AW];
  assign w_rt     = r_ir[16 +: AW];
  assign w_rd     = r_ir[11 +: AW];
  assign w_imm    = {{(XLEN-16){r_ir[15]}}, r_ir[15:0]};
  assign w_pc_br  = r_pc + {w_imm[XLEN-3:0], 2'b00};
  assign w_pc_jmp = {r_pc[XLEN-1:28], r_ir[25:0], 2'b00};
  assign w_pc_next = (r_a == r_b) ? w_pc_br : r_pc;

  // Outside EXEC the ALU serves as the immediate adder for addi and lw/sw.
  assign w_alu_b    = (r_state == S_EXEC) ? r_b : w_imm;
  assign w_alu_ctrl = (r_state == S_EXEC) ? funct_to_alu(w_funct) : ALU_ADD;

  always_comb begin
    w_alu_y = r_a + w_alu_b;
    case (w_alu_ctrl)
      ALU_SUB: w_alu_y = r_a - w_alu_b;
      ALU_AND: w_alu_y = r_a & w_alu_b;
      ALU_OR:  w_alu_y = r_a | w_alu_b;
      ALU_SLT: w_alu_y = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(w_alu_b))};
      default: w_alu_y = r_a + w_alu_b;
    endcase
  end

  always_comb begin
    w_dec_state = S_HALT;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: w_dec_state = S_EXEC;
`ifdef MC_DATAPATH_JAL_EN
          FN_JR: w_dec_state = S_JREG;
`endif
          default: w_dec_state = S_HALT;
        endcase
      end
      OP_ADDI:     w_dec_state = S_ADDIEX;
      OP_LW, OP_SW: w_dec_state = S_MEMADR;
      OP_BEQ:      w_dec_state = S_BRANCH;
      OP_J:        w_dec_state = S_JUMP;
`ifdef MC_DATAPATH_JAL_EN
      OP_JAL:      w_dec_state = S_JUMP;
`endif
      default:     w_dec_state = S_HALT;
    endcase
  end

  always_comb begin
    w_wa = w_rt;
    w_wd = r_aluout;
    case (r_state)
      S_ALUWB: if (w_op == OP_RTYPE) w_wa = w_rd;
      S_MEMWB: w_wd = r_mdr;
`ifdef MC_DATAPATH_JAL_EN
      S_JUMP: begin
        w_wa = AW'(NREG - 1);
        w_wd = r_pc;
      end
`endif
      default: ;
    endcase
  end

  mc_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .i_ra1   (w_rs),
    .i_ra2   (w_rt),
    .i_we    (r_reg_we),
    .i_wa    (w_wa),
    .i_wd    (w_wd),
    .o_rd1   (w_rd1),
    .o_rd2   (w_rd2)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_aluout    <= '0;
      r_mdr       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= RESET_PC;
      r_mem_wdata <= '0;
      r_reg_we    <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_reg_we <= 1'b0;
      case (r_state)
        S_FETCH: begin
          // First cycle out of reset only raises the request.
          if (!r_mem_req) begin
            r_mem_req <= 1'b1;
          end else if (mem_ready) begin
            r_ir      <= mem_rdata;
            r_pc      <= r_pc + XLEN'(4);
            r_mem_req <= 1'b0;
            r_state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a     <= w_rd1;
          r_b     <= w_rd2;
          r_state <= w_dec_state;
          if (w_dec_state == S_HALT) r_halted <= 1'b1;
`ifdef MC_DATAPATH_JAL_EN
          if (w_op == OP_JAL) r_reg_we <= 1'b1;
`endif
        end
        S_EXEC, S_ADDIEX: begin
          r_aluout <= w_alu_y;
          r_reg_we <= 1'b1;
          r_state  <= S_ALUWB;
        end
        S_ALUWB, S_MEMWB: begin
          r_mem_req  <= 1'b1;
          r_mem_addr <= r_pc;
          r_state    <= S_FETCH;
        end
        S_MEMADR: begin
          r_aluout   <= w_alu_y;
          r_mem_addr <= w_alu_y;
          r_mem_req  <= 1'b1;
          if (w_op == OP_SW) begin
            r_mem_we    <= 1'b1;
            r_mem_wdata <= r_b;
            r_state     <= S_MEMWR;
          end else begin
            r_state <= S_MEMRD;
          end
        end
        S_MEMRD: begin
          if (mem_ready) begin
            r_mdr     <= mem_rdata;
            r_mem_req <= 1'b0;
            r_reg_we  <= 1'b1;
            r_state   <= S_MEMWB;
          end
        end
        S_MEMWR: begin
          if (mem_ready) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_pc;
            r_state    <= S_FETCH;
          end
        end
        S_BRANCH: begin
          r_pc       <= w_pc_next;
          r_mem_addr <= w_pc_next;
          r_mem_req  <= 1'b1;
          r_state    <= S_FETCH;
        end
        S_JUMP: begin
          r_pc       <= w_pc_jmp;
          r_mem_addr <= w_pc_jmp;
          r_mem_req  <= 1'b1;
          r_state    <= S_FETCH;
        end
        S_JREG: begin
          r_pc       <= r_a;
          r_mem_addr <= r_a;
          r_mem_req  <= 1'b1;
          r_state    <= S_FETCH;
        end
        S_HALT: r_state <= S_HALT;
        default: begin
          r_halted <= 1'b1;
          r_state  <= S_HALT;
        end
      endcase
    end
  end

  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign pc_q         = r_pc;
  assign instr        = r_ir;
  assign reg_write_en = r_reg_we;
  assign halted       = r_halted;

endmodule
